// File: rtl/prefetcher_stub_pkg.sv
// Shared types for the AXI read memory stub: engine states, response codes
// and the AR queue entry layout.
package prefetcher_stub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        BEAT = 2'd2
    } engine_state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Queue entry fields are sized for the widest supported configuration;
    // the stub zero-extends on push and truncates on pop.
    localparam int AR_ADDR_MAX = 64;
    localparam int AR_LEN_MAX  = 16;
    localparam int AR_ID_MAX   = 32;

    typedef struct packed {
        logic [AR_ADDR_MAX-1:0] addr;
        logic [AR_LEN_MAX-1:0]  len;
        logic [AR_ID_MAX-1:0]   id;
    } ar_entry_t;

endpackage

// File: rtl/stub_ar_fifo.sv
// Small synchronous FIFO holding queued AR requests. The head entry is
// visible combinationally so the engine can load it on the pop edge.
module stub_ar_fifo #(
    parameter int WIDTH     = 8,
    parameter int LOG_DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push,
    input  logic [WIDTH-1:0]     push_data,
    input  logic                 pop,
    output logic [WIDTH-1:0]     head,
    output logic                 full,
    output logic                 empty,
    output logic [LOG_DEPTH:0]   count
);

    localparam int DEPTH = 1 << LOG_DEPTH;

    logic [WIDTH-1:0]     store_r [DEPTH];
    logic [LOG_DEPTH-1:0] wr_ptr_r;
    logic [LOG_DEPTH-1:0] rd_ptr_r;
    logic [LOG_DEPTH:0]   cnt_r;
    logic                 do_push_s;
    logic                 do_pop_s;

    assign full      = (cnt_r == (LOG_DEPTH+1)'(DEPTH));
    assign empty     = (cnt_r == {(LOG_DEPTH+1){1'b0}});
    assign count     = cnt_r;
    assign head      = store_r[rd_ptr_r];
    assign do_push_s = push && !full;
    assign do_pop_s  = pop && !empty;

    // Entry storage; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            store_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {LOG_DEPTH{1'b0}};
            rd_ptr_r <= {LOG_DEPTH{1'b0}};
            cnt_r    <= {(LOG_DEPTH+1){1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + LOG_DEPTH'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + LOG_DEPTH'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   cnt_r <= cnt_r + (LOG_DEPTH+1)'(1);
                2'b01:   cnt_r <= cnt_r - (LOG_DEPTH+1)'(1);
                default: cnt_r <= cnt_r;
            endcase
        end
    end

endmodule

// File: rtl/axi_rd_mem_stub.sv
// AXI4 read-slave memory model: queues INCR bursts in order, waits a
// programmable latency before each burst, streams beats with stable payload
// under backpressure and answers out-of-range words with SLVERR.
module axi_rd_mem_stub #(
    parameter int ADDR_BITS            = 16,
    parameter int LOG_BLOCK_DATA_BYTES = 0,
    parameter int MEM_WORD_BITS        = 8,
    parameter int BURST_LEN_WIDTH      = 8,
    parameter int TID_WIDTH            = 8,
    parameter int LOG_OUTSTANDING      = 2,
    parameter int LAT_WIDTH            = 6,
    localparam int DATA_WIDTH          = 8 << LOG_BLOCK_DATA_BYTES
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       s_ar_valid,
    output logic                       s_ar_ready,
    input  logic [ADDR_BITS-1:0]       s_ar_addr,
    input  logic [BURST_LEN_WIDTH-1:0] s_ar_len,
    input  logic [TID_WIDTH-1:0]       s_ar_id,
    output logic                       s_r_valid,
    input  logic                       s_r_ready,
    output logic [DATA_WIDTH-1:0]      s_r_data,
    output logic [TID_WIDTH-1:0]       s_r_id,
    output logic                       s_r_last,
    output logic [1:0]                 s_r_resp,
    input  logic [LAT_WIDTH-1:0]       cfg_latency,
    input  logic                       ld_en,
    input  logic [MEM_WORD_BITS-1:0]   ld_addr,
    input  logic [DATA_WIDTH-1:0]      ld_data,
    output logic [LOG_OUTSTANDING:0]   outstanding,
    output logic                       busy
);

    import prefetcher_stub_pkg::*;

    localparam int IDX_W  = ADDR_BITS - LOG_BLOCK_DATA_BYTES;
    localparam int WIDE_W = IDX_W + MEM_WORD_BITS;

    logic [DATA_WIDTH-1:0]      mem_r [1 << MEM_WORD_BITS];

    ar_entry_t                  push_entry_s;
    ar_entry_t                  head_entry_s;
    logic                       fifo_full_s;
    logic                       fifo_empty_s;
    logic [LOG_OUTSTANDING:0]   fifo_count_s;
    logic                       pop_s;

    logic [IDX_W-1:0]           head_idx_s;
    logic [BURST_LEN_WIDTH-1:0] head_len_s;
    logic [TID_WIDTH-1:0]       head_id_s;

    engine_state_t              state_r;
    logic [IDX_W-1:0]           cur_idx_r;
    logic [BURST_LEN_WIDTH-1:0] beat_r;
    logic [BURST_LEN_WIDTH-1:0] len_r;
    logic [TID_WIDTH-1:0]       id_r;
    logic [LAT_WIDTH-1:0]       lat_r;
    logic                       r_valid_r;
    logic [DATA_WIDTH-1:0]      r_data_r;
    logic [TID_WIDTH-1:0]       r_id_r;
    logic                       r_last_r;
    logic [1:0]                 r_resp_r;

    logic [IDX_W-1:0]           cap_idx_s;
    logic [BURST_LEN_WIDTH-1:0] cap_beat_s;
    logic [BURST_LEN_WIDTH-1:0] cap_len_s;
    logic [TID_WIDTH-1:0]       cap_id_s;
    logic [WIDE_W-1:0]          cap_wide_s;
    logic                       cap_in_range_s;
    logic [DATA_WIDTH-1:0]      cap_data_s;
    logic [1:0]                 cap_resp_s;
    logic                       cap_last_s;
    logic                       capture_s;

    // Widen the incoming request into the queue entry layout.
    always_comb begin
        push_entry_s.addr = AR_ADDR_MAX'(s_ar_addr);
        push_entry_s.len  = AR_LEN_MAX'(s_ar_len);
        push_entry_s.id   = AR_ID_MAX'(s_ar_id);
    end

    assign head_idx_s = IDX_W'(ADDR_BITS'(head_entry_s.addr) >> LOG_BLOCK_DATA_BYTES);
    assign head_len_s = BURST_LEN_WIDTH'(head_entry_s.len);
    assign head_id_s  = TID_WIDTH'(head_entry_s.id);
    assign pop_s      = (state_r == IDLE) && !fifo_empty_s;

    stub_ar_fifo #(
        .WIDTH     ($bits(ar_entry_t)),
        .LOG_DEPTH (LOG_OUTSTANDING)
    ) u_ar_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (s_ar_valid),
        .push_data (push_entry_s),
        .pop       (pop_s),
        .head      (head_entry_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s),
        .count     (fifo_count_s)
    );

    // Preload port; memory is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (ld_en) begin
            mem_r[ld_addr] <= ld_data;
        end
    end

    // Select the beat to capture next: the queue head while idle, otherwise
    // the running burst position; also decide whether a capture happens.
    always_comb begin
        cap_idx_s  = cur_idx_r;
        cap_beat_s = beat_r;
        cap_len_s  = len_r;
        cap_id_s   = id_r;
        if (state_r == IDLE) begin
            cap_idx_s  = head_idx_s;
            cap_beat_s = {BURST_LEN_WIDTH{1'b0}};
            cap_len_s  = head_len_s;
            cap_id_s   = head_id_s;
        end else begin
            cap_idx_s  = cur_idx_r;
        end
        cap_wide_s     = WIDE_W'(cap_idx_s);
        cap_in_range_s = ((cap_wide_s >> MEM_WORD_BITS) == {WIDE_W{1'b0}});
        if (cap_in_range_s) begin
            cap_data_s = mem_r[cap_wide_s[MEM_WORD_BITS-1:0]];
            cap_resp_s = RESP_OKAY;
        end else begin
            cap_data_s = {DATA_WIDTH{1'b0}};
            cap_resp_s = RESP_SLVERR;
        end
        cap_last_s = (cap_beat_s == cap_len_s);
        case (state_r)
            IDLE:    capture_s = !fifo_empty_s && (cfg_latency == {LAT_WIDTH{1'b0}});
            WAIT:    capture_s = (lat_r == LAT_WIDTH'(1));
            BEAT:    capture_s = s_r_ready && !r_last_r;
            default: capture_s = 1'b0;
        endcase
    end

    // Burst engine: load from queue, count latency, stream registered beats.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            cur_idx_r <= {IDX_W{1'b0}};
            beat_r    <= {BURST_LEN_WIDTH{1'b0}};
            len_r     <= {BURST_LEN_WIDTH{1'b0}};
            id_r      <= {TID_WIDTH{1'b0}};
            lat_r     <= {LAT_WIDTH{1'b0}};
            r_valid_r <= 1'b0;
            r_data_r  <= {DATA_WIDTH{1'b0}};
            r_id_r    <= {TID_WIDTH{1'b0}};
            r_last_r  <= 1'b0;
            r_resp_r  <= RESP_OKAY;
        end else begin
            case (state_r)
                IDLE: begin
                    if (!fifo_empty_s) begin
                        len_r     <= head_len_s;
                        id_r      <= head_id_s;
                        lat_r     <= cfg_latency;
                        cur_idx_r <= head_idx_s;
                        beat_r    <= {BURST_LEN_WIDTH{1'b0}};
                        state_r   <= capture_s ? BEAT : WAIT;
                    end
                end
                WAIT: begin
                    if (capture_s) begin
                        state_r <= BEAT;
                    end else begin
                        lat_r <= lat_r - LAT_WIDTH'(1);
                    end
                end
                BEAT: begin
                    if (s_r_ready && r_last_r) begin
                        r_valid_r <= 1'b0;
                        r_last_r  <= 1'b0;
                        state_r   <= IDLE;
                    end
                end
                default: state_r <= IDLE;
            endcase
            // A capture overrides the load defaults above for position/payload.
            if (capture_s) begin
                r_valid_r <= 1'b1;
                r_data_r  <= cap_data_s;
                r_resp_r  <= cap_resp_s;
                r_last_r  <= cap_last_s;
                r_id_r    <= cap_id_s;
                cur_idx_r <= cap_idx_s + IDX_W'(1);
                beat_r    <= cap_beat_s + BURST_LEN_WIDTH'(1);
            end
        end
    end

    assign s_ar_ready  = !fifo_full_s;
    assign s_r_valid   = r_valid_r;
    assign s_r_data    = r_data_r;
    assign s_r_id      = r_id_r;
    assign s_r_last    = r_last_r;
    assign s_r_resp    = r_resp_r;
    assign busy        = (state_r != IDLE);
    assign outstanding = fifo_count_s + (LOG_OUTSTANDING+1)'(busy);

endmodule

// File: tb/tb_axi_rd_mem_stub.sv
// Self-checking bench for axi_rd_mem_stub: table of single-burst vectors
// plus hand-written sequences for queue-full and mid-burst reset.
module tb_axi_rd_mem_stub;

    logic        clk = 1'b0;
    logic        rst;
    logic        s_ar_valid;
    logic        s_ar_ready;
    logic [15:0] s_ar_addr;
    logic [7:0]  s_ar_len;
    logic [7:0]  s_ar_id;
    logic        s_r_valid;
    logic        s_r_ready;
    logic [7:0]  s_r_data;
    logic [7:0]  s_r_id;
    logic        s_r_last;
    logic [1:0]  s_r_resp;
    logic [5:0]  cfg_latency;
    logic        ld_en;
    logic [7:0]  ld_addr;
    logic [7:0]  ld_data;
    logic [2:0]  outstanding;
    logic        busy;

    axi_rd_mem_stub dut (
        .clk         (clk),
        .rst         (rst),
        .s_ar_valid  (s_ar_valid),
        .s_ar_ready  (s_ar_ready),
        .s_ar_addr   (s_ar_addr),
        .s_ar_len    (s_ar_len),
        .s_ar_id     (s_ar_id),
        .s_r_valid   (s_r_valid),
        .s_r_ready   (s_r_ready),
        .s_r_data    (s_r_data),
        .s_r_id      (s_r_id),
        .s_r_last    (s_r_last),
        .s_r_resp    (s_r_resp),
        .cfg_latency (cfg_latency),
        .ld_en       (ld_en),
        .ld_addr     (ld_addr),
        .ld_data     (ld_data),
        .outstanding (outstanding),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic [7:0] id;
        logic       last;
        logic [1:0] resp;
    } beat_t;

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  len;
        logic [7:0]  id;
        logic [5:0]  lat;
        int          stall_beat;
        int          stall_cyc;
        logic [7:0]  exp_d0;
        logic [1:0]  exp_resp0;
    } vec_t;

    beat_t      sb[$];
    vec_t       vecs[5];
    logic [7:0] model [256];
    int         n_chk  = 0;
    int         n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected beats of a burst, from the bench's own memory image.
    task automatic push_expect(input logic [15:0] a, input logic [7:0] l, input logic [7:0] id);
        beat_t       e;
        logic [15:0] idx;
        for (int n = 0; n <= int'(l); n++) begin
            idx = a + 16'(n);
            if (idx < 16'd256) begin
                e.data = model[idx[7:0]];
                e.resp = 2'b00;
            end else begin
                e.data = 8'h00;
                e.resp = 2'b10;
            end
            e.id   = id;
            e.last = (n == int'(l));
            sb.push_back(e);
        end
    endtask

    // Present an AR at a falling edge; returns at the falling edge after the
    // accepting rising edge, or after 'tries' cycles without acceptance.
    task automatic send_ar(input logic [15:0] a, input logic [7:0] l, input logic [7:0] id,
                           input int tries, output bit ok);
        ok = 1'b0;
        s_ar_valid = 1'b1;
        s_ar_addr  = a;
        s_ar_len   = l;
        s_ar_id    = id;
        for (int t = 0; t < tries && !ok; t++) begin
            if (s_ar_ready) begin
                ok = 1'b1;
                push_expect(a, l, id);
            end
            @(negedge clk);
        end
        s_ar_valid = 1'b0;
    endtask

    // Consume beats against the scoreboard, stalling on one beat if asked.
    task automatic drain(input int stall_beat, input int stall_cyc, input int max_beats);
        beat_t e;
        int    beat = 0;
        int    stall = stall_cyc;
        int    hs = 0;
        int    cyc = 0;
        bit    prev_last = 1'b0;
        while (sb.size() > 0 && hs < max_beats && cyc < 400) begin
            if (prev_last) begin
                chk("gap_between_bursts", s_r_valid, 1'b0);
                prev_last = 1'b0;
            end
            if (s_r_valid) begin
                e = sb[0];
                chk("r_data", s_r_data, e.data);
                chk("r_id",   s_r_id,   e.id);
                chk("r_last", s_r_last, e.last);
                chk("r_resp", s_r_resp, e.resp);
                if (beat == stall_beat && stall > 0) begin
                    s_r_ready = 1'b0;
                    stall--;
                end else begin
                    s_r_ready = 1'b1;
                    hs++;
                    void'(sb.pop_front());
                    prev_last = e.last;
                    beat = e.last ? 0 : beat + 1;
                end
            end else begin
                s_r_ready = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        s_r_ready = 1'b0;
        chk("drain_timeout", (cyc >= 400) ? 1'b1 : 1'b0, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit ok;

        vecs[0] = '{16'h0010, 8'd0, 8'd5,  6'd0, -1, 0, 8'hA5, 2'b00};
        vecs[1] = '{16'h0020, 8'd3, 8'd7,  6'd3,  1, 4, 8'hE3, 2'b00};
        vecs[2] = '{16'h0100, 8'd1, 8'd9,  6'd0, -1, 0, 8'h00, 2'b10};
        vecs[3] = '{16'h00FF, 8'd1, 8'd10, 6'd1,  0, 2, 8'hFC, 2'b00};
        vecs[4] = '{16'h0045, 8'd2, 8'd3,  6'd2,  2, 1, 8'hE6, 2'b00};

        rst = 1'b1;
        s_ar_valid = 1'b0;
        s_ar_addr = 16'h0;
        s_ar_len = 8'h0;
        s_ar_id = 8'h0;
        s_r_ready = 1'b0;
        cfg_latency = 6'd0;
        ld_en = 1'b0;
        ld_addr = 8'h0;
        ld_data = 8'h0;
        repeat (3) @(negedge clk);

        chk("rst_ar_ready",    s_ar_ready,  1'b1);
        chk("rst_r_valid",     s_r_valid,   1'b0);
        chk("rst_r_last",      s_r_last,    1'b0);
        chk("rst_r_resp",      s_r_resp,    2'b00);
        chk("rst_r_data",      s_r_data,    8'h00);
        chk("rst_r_id",        s_r_id,      8'h00);
        chk("rst_outstanding", outstanding, 3'd0);
        chk("rst_busy",        busy,        1'b0);
        rst = 1'b0;

        // Preload a known pattern, then the single-beat test word.
        for (int i = 0; i < 256; i++) begin
            model[i] = 8'((i * 7) + 3);
            ld_en    = 1'b1;
            ld_addr  = 8'(i);
            ld_data  = model[i];
            @(negedge clk);
        end
        model[8'h10] = 8'hA5;
        ld_addr = 8'h10;
        ld_data = 8'hA5;
        @(negedge clk);
        ld_en = 1'b0;
        @(negedge clk);

        // Table vectors: latency, first beat, then full burst via scoreboard.
        for (int v = 0; v < 5; v++) begin
            cfg_latency = vecs[v].lat;
            send_ar(vecs[v].addr, vecs[v].len, vecs[v].id, 20, ok);
            chk("ar_accept", ok, 1'b1);
            for (int i = 0; i <= int'(vecs[v].lat); i++) begin
                chk("latency_not_yet_valid", s_r_valid, 1'b0);
                @(negedge clk);
            end
            chk("latency_first_valid", s_r_valid, 1'b1);
            chk("first_beat_data", s_r_data, vecs[v].exp_d0);
            chk("first_beat_resp", s_r_resp, vecs[v].exp_resp0);
            drain(vecs[v].stall_beat, vecs[v].stall_cyc, 1000);
            chk("idle_after_burst", busy, 1'b0);
        end

        // Queue-full: five accepted with the engine stalled, sixth refused.
        cfg_latency = 6'd0;
        s_r_ready   = 1'b0;
        for (int i = 0; i < 5; i++) begin
            send_ar(16'h0040 + 16'(i * 4), 8'd1, 8'h20 + 8'(i), 20, ok);
            chk("fill_accept", ok, 1'b1);
        end
        chk("full_ar_ready",    s_ar_ready,  1'b0);
        chk("full_outstanding", outstanding, 3'd5);
        chk("full_busy",        busy,        1'b1);
        send_ar(16'h0060, 8'd0, 8'h2F, 3, ok);
        chk("sixth_refused",     ok,          1'b0);
        chk("still_outstanding", outstanding, 3'd5);
        drain(-1, 0, 1000);
        chk("drained_outstanding", outstanding, 3'd0);
        chk("drained_ar_ready",    s_ar_ready,  1'b1);

        // Reset while beat 2 of an eight-beat burst is on the bus.
        send_ar(16'h0030, 8'd7, 8'h33, 20, ok);
        chk("long_accept", ok, 1'b1);
        drain(-1, 0, 2);
        chk("beat2_valid", s_r_valid, 1'b1);
        chk("beat2_data",  s_r_data,  model[8'h32]);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_r_valid",     s_r_valid,   1'b0);
        chk("midrst_outstanding", outstanding, 3'd0);
        chk("midrst_ar_ready",    s_ar_ready,  1'b1);
        chk("midrst_busy",        busy,        1'b0);
        rst = 1'b0;
        sb.delete();
        @(negedge clk);
        send_ar(16'h0010, 8'd1, 8'h44, 20, ok);
        chk("post_rst_accept", ok, 1'b1);
        drain(-1, 0, 1000);
        chk("post_rst_idle", busy, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/axi_rd_mem_stub.md
Name: axi_rd_mem_stub

Overview:
- Parametrised AXI4 read-slave memory model for prefetcher benches. It replaces the fixed single-burst RAM stub on the prefetcher's master AR/R side.
- Queues multiple outstanding INCR bursts in order, applies a programmable per-burst latency and holds R payloads stable under backpressure.
- Flags out-of-range reads with SLVERR. A side port preloads memory contents.

Parameters:
- ADDR_BITS, 16, AR address width (byte address).
- LOG_BLOCK_DATA_BYTES, 0, log2 bytes per beat; DATA_WIDTH = 8<<LOG_BLOCK_DATA_BYTES.
- MEM_WORD_BITS, 8, log2 number of words in the memory array.
- BURST_LEN_WIDTH, 8, width of ar_len; beats = len+1.
- TID_WIDTH, 8, transaction ID width.
- LOG_OUTSTANDING, 2, log2 depth of the AR queue.
- LAT_WIDTH, 6, width of cfg_latency.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- s_ar_valid  in  1  read request valid.
- s_ar_ready  out  1  request accepted when high with valid.
- s_ar_addr  in  ADDR_BITS  burst start byte address.
- s_ar_len  in  BURST_LEN_WIDTH  beats minus one.
- s_ar_id  in  TID_WIDTH  request ID.
- s_r_valid  out  1  read data valid.
- s_r_ready  in  1  master accepts beat.
- s_r_data  out  DATA_WIDTH  beat data.
- s_r_id  out  TID_WIDTH  ID of current burst.
- s_r_last  out  1  final beat of burst.
- s_r_resp  out  2  2'b00 OKAY, 2'b10 SLVERR.
- cfg_latency  in  LAT_WIDTH  extra wait cycles before each burst's first beat; sampled when the burst is loaded.
- ld_en  in  1  preload write strobe.
- ld_addr  in  MEM_WORD_BITS  preload word index.
- ld_data  in  DATA_WIDTH  preload data.
- outstanding  out  LOG_OUTSTANDING+1  queued + active bursts.
- busy  out  1  engine not IDLE.

Behaviour:
- Reset values: s_ar_ready=1, s_r_valid=0, s_r_last=0, s_r_resp=0, s_r_data=0, s_r_id=0, outstanding=0, busy=0. Queue is emptied. Memory contents are NOT reset.
- Reset mid-burst: the burst is dropped and s_r_valid is low in the cycle after the reset edge.
- AR queue is a FIFO of {addr,len,id}. s_ar_ready = !full, computed from the current count only; no accept while full, even if a pop happens in the same cycle.
- Push and pop in the same cycle is legal when not full.
- Word index = addr >> LOG_BLOCK_DATA_BYTES.
- In range means index < 2^MEM_WORD_BITS and upper address bits are zero.
- Beat n reads word index+n. The beat counter is BURST_LEN_WIDTH wide. The index is ADDR_BITS-LOG_BLOCK_DATA_BYTES wide and wraps at its width; an index that overflows the array is out of range.
- Out-of-range beat: s_r_data=0, s_r_resp=2'b10, burst continues to len+1 beats.
- Engine FSM states are IDLE, WAIT and BEAT.
- IDLE:
  - If the queue is non-empty: pop the head and load addr, len, id and lat_cnt=cfg_latency.
  - If cfg_latency==0, go to BEAT and capture beat 0 on this same edge; else go to WAIT.
- WAIT: lat_cnt decrements each cycle. On the edge where lat_cnt==1, go to BEAT and capture beat 0.
- BEAT:
  - s_r_valid=1; payload is registered and stable while !s_r_ready.
  - On handshake with a non-last beat: capture the next beat on the same edge (back-to-back, no bubble).
  - On handshake with the last beat: go to IDLE; valid drops for at least one cycle between bursts.
- Latency rule: with the engine idle and an AR handshake at edge k, the first beat is valid after edge k+1+cfg_latency.
- s_r_last=1 exactly on beat len.
- Preload: mem[ld_addr]<=ld_data on the edge when ld_en is high.
- Preload and beat capture of the same word on the same edge: the old data is captured.
- outstanding = queue count + (state!=IDLE). busy = (state!=IDLE).

Decomposition:
- Package prefetcher_stub_pkg holds:
  - engine state enum {IDLE, WAIT, BEAT};
  - RESP_OKAY=2'b00 and RESP_SLVERR=2'b10;
  - the AR queue entry struct type.
- One sub-module, stub_ar_fifo: parametrised synchronous FIFO with full/empty/count outputs and the same reset.

Test Plan:
- Single beat, cfg_latency=0: preload mem[0x10]=0xA5, AR addr=0x10 len=0 id=5 at edge k. Expect r_valid after edge k+1, data=0xA5, id=5, last=1, resp=0.
- Latency and backpressure: cfg_latency=3, AR len=3 at 0x20, r_ready low for 4 cycles on beat 1. Expect:
  - first valid after edge k+4;
  - beat 1 data stable while stalled;
  - data mem[0x20..0x23] in order;
  - last only on beat 3.
- Outstanding limit, LOG_OUTSTANDING=2, r_ready=0: issue 6 ARs. Expect:
  - 5 accepted (4 queued + 1 active);
  - s_ar_ready=0 and outstanding=5;
  - releasing r_ready returns bursts in issue order with matching IDs.
- Out of range: AR addr=0x0100 (MEM_WORD_BITS=8) len=1. Expect 2 beats, resp=2'b10, data=0, last on beat 1. Also AR at 0x00FF len=1: beat 0 OKAY, beat 1 SLVERR.
- Reset mid-burst: assert rst during beat 2 of a len=7 burst. Expect:
  - r_valid=0 and outstanding=0 after the edge;
  - s_ar_ready=1;
  - a new AR is then served normally with preloaded data intact.
